// File: rtl/rx_fifo_pkg.sv
// Shared types and constants for the RX sample FIFO: write FSM states and packing sizes.
package rx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W0   = 2'd1,
    W1   = 2'd2,
    W2   = 2'd3
  } wr_state_e;

  localparam int          WORDS_PER_SAMPLE = 3;
  localparam logic [15:0] OVF_CNT_MAX      = 16'hFFFF;

endpackage

// File: rtl/rx_fifo_ram.sv
// Simple dual-port 16-bit word store: one write port and one registered read port.
// The array itself has no reset, so it maps onto block RAM.
module rx_fifo_ram #(
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [15:0]           wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [15:0]           rdata
);

  logic [15:0] mem [0:(1 << DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; it holds its value when no read is issued.
  always_ff @(posedge clk) begin
    if (!reset_n) rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/rx_sample_fifo.sv
// Captures decimated I/Q pairs, packs each into three 16-bit words and buffers them for the CPU reader.
// Optional RX_FIFO_OVF_CNT_EN adds a saturating 16-bit dropped-sample counter port.
module rx_sample_fifo
  import rx_fifo_pkg::*;
#(
  parameter int WIDTH      = 24,
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  adc_clk,
  input  logic                  reset_n,
  input  logic                  in_strobe,
  input  logic [WIDTH-1:0]      in_i,
  input  logic [WIDTH-1:0]      in_q,
  input  logic                  clr,
  input  logic                  rd,
  output logic [15:0]           dout,
  output logic                  dout_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  ovf,
`ifdef RX_FIFO_OVF_CNT_EN
  output logic [15:0]           ovf_cnt,
`endif
  output logic [1:0]            wr_state
);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] ADMIT_MAX =
    (DEPTH_LOG2+1)'((1 << DEPTH_LOG2) - WORDS_PER_SAMPLE);

  wr_state_e             state;
  logic [15:0]           hold_w0, hold_w1, hold_w2;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  we, re, admit, drop;
  logic [15:0]           wdata;
  logic [DEPTH_LOG2:0]   count_next;

  // Admission looks only at IDLE and free space, so an accepted sample always fits whole.
  always_comb begin
    we         = !clr && (state != IDLE);
    re         = !clr && rd && (count != '0);
    admit      = !clr && in_strobe && (state == IDLE) && (count <= ADMIT_MAX);
    drop       = !clr && in_strobe && !admit;
    count_next = count + (DEPTH_LOG2+1)'(we) - (DEPTH_LOG2+1)'(re);
    case (state)
      W0:      wdata = hold_w0;
      W1:      wdata = hold_w1;
      default: wdata = hold_w2;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (!reset_n || clr) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      ovf        <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= re;
      case (state)
        IDLE:    if (admit) state <= W0;
        W0:      state <= W1;
        W1:      state <= W2;
        default: state <= IDLE;
      endcase
      if (we)   wr_ptr <= wr_ptr + 1'b1;
      if (re)   rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == DEPTH_CNT);
      if (drop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (admit) begin
      hold_w0 <= in_i[WIDTH-1 -: 16];
      hold_w1 <= in_q[WIDTH-1 -: 16];
      hold_w2 <= {in_i[WIDTH-17 -: 8], in_q[WIDTH-17 -: 8]};
    end
  end

`ifdef RX_FIFO_OVF_CNT_EN
  always_ff @(posedge adc_clk) begin
    if (!reset_n || clr)                 ovf_cnt <= '0;
    else if (drop && ovf_cnt != OVF_CNT_MAX) ovf_cnt <= ovf_cnt + 16'd1;
  end
`endif

  assign wr_state = state;

  rx_fifo_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk     (adc_clk),
    .reset_n (reset_n),
    .we      (we),
    .waddr   (wr_ptr),
    .wdata   (wdata),
    .re      (re),
    .raddr   (rd_ptr),
    .rdata   (dout)
  );

endmodule

// File: tb/tb_rx_sample_fifo.sv
// Self-checking bench for rx_sample_fifo (WIDTH=24, 16-word buffer) against a queue-based reference model.
module tb_rx_sample_fifo;
  import rx_fifo_pkg::*;

  localparam int W     = 24;
  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic          adc_clk = 1'b0;
  logic          reset_n;
  logic          in_strobe;
  logic [W-1:0]  in_i, in_q;
  logic          clr, rd;
  logic [15:0]   dout;
  logic          dout_valid;
  logic [DL:0]   count;
  logic          empty, full, ovf;
  logic [1:0]    wr_state;
`ifdef RX_FIFO_OVF_CNT_EN
  logic [15:0]   ovf_cnt;
`endif

  always #5 adc_clk = ~adc_clk;

  rx_sample_fifo #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
    .adc_clk    (adc_clk),
    .reset_n    (reset_n),
    .in_strobe  (in_strobe),
    .in_i       (in_i),
    .in_q       (in_q),
    .clr        (clr),
    .rd         (rd),
    .dout       (dout),
    .dout_valid (dout_valid),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .ovf        (ovf),
`ifdef RX_FIFO_OVF_CNT_EN
    .ovf_cnt    (ovf_cnt),
`endif
    .wr_state   (wr_state)
  );

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] pend_q[$];
  logic [15:0] exp_dout;
  logic        exp_valid;
  logic        exp_ovf;
  int          exp_ovf_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pend_q.delete();
    exp_ovf     = 1'b0;
    exp_ovf_cnt = 0;
    exp_valid   = 1'b0;
  endtask

  task automatic check_outputs();
    check("dout_valid", 32'(dout_valid), 32'(exp_valid));
    check("dout", 32'(dout), 32'(exp_dout));
    check("count", 32'(count), 32'(exp_q.size()));
    check("empty", 32'(empty), 32'(exp_q.size() == 0));
    check("full", 32'(full), 32'(exp_q.size() == DEPTH));
    check("ovf", 32'(ovf), 32'(exp_ovf));
`ifdef RX_FIFO_OVF_CNT_EN
    check("ovf_cnt", 32'(ovf_cnt), 32'(exp_ovf_cnt));
`endif
    check("fsm_idle", 32'(wr_state == IDLE), 32'(pend_q.size() == 0));
  endtask

  // One clock: apply inputs, advance the model by the spec's rules, check just after the edge.
  task automatic step(input logic s, input logic [W-1:0] i, input logic [W-1:0] q,
                      input logic r, input logic c);
    in_strobe = s; in_i = i; in_q = q; rd = r; clr = c;
    @(posedge adc_clk);
    if (!reset_n) begin
      model_clear();
      exp_dout = 16'h0;
    end else if (c) begin
      model_clear();
    end else begin
      int stored = exp_q.size();
      bit idle   = (pend_q.size() == 0);
      exp_valid = 1'b0;
      if (r && stored != 0) begin
        exp_dout  = exp_q.pop_front();
        exp_valid = 1'b1;
      end
      if (!idle) exp_q.push_back(pend_q.pop_front());
      if (s) begin
        if (idle && stored + 3 <= DEPTH) begin
          pend_q.push_back(i[23:8]);
          pend_q.push_back(q[23:8]);
          pend_q.push_back({i[7:0], q[7:0]});
        end else begin
          exp_ovf = 1'b1;
          if (exp_ovf_cnt < 65535) exp_ovf_cnt++;
        end
      end
    end
    #1;
    check_outputs();
    in_strobe = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    while (exp_q.size() != 0 || pend_q.size() != 0) step(1'b0, '0, '0, 1'b1, 1'b0);
    idle_n(1);
  endtask

  initial begin
    reset_n = 1'b0; in_strobe = 1'b0; in_i = '0; in_q = '0; clr = 1'b0; rd = 1'b0;
    exp_dout = 16'h0;
    model_clear();
    #2;
    // reset state
    step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    reset_n = 1'b1;
    idle_n(2);

    // single sample and its three words in order
    step(1'b1, 24'h123456, 24'hABCDEF, 1'b0, 1'b0);
    idle_n(3);
    check("single_count3", 32'(count), 32'd3);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("single_w0", 32'(dout), 32'h1234);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("single_w1", 32'(dout), 32'hABCD);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("single_w2", 32'(dout), 32'h56EF);
    check("single_empty", 32'(empty), 32'd1);
    // read while empty is ignored
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // overrun spacing: second strobe two cycles later is dropped
    step(1'b1, 24'h111111, 24'h222222, 1'b0, 1'b0);
    idle_n(1);
    step(1'b1, 24'h333333, 24'h444444, 1'b0, 1'b0);
    idle_n(3);
    check("ovr_count", 32'(count), 32'd3);
    check("ovr_ovf", 32'(ovf), 32'd1);
`ifdef RX_FIFO_OVF_CNT_EN
    check("ovr_ovf_cnt", 32'(ovf_cnt), 32'd1);
`endif
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // full: five samples fit in 15 words, the sixth is dropped
    for (int k = 0; k < 6; k++) begin
      step(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
      idle_n(3);
    end
    check("full_count15", 32'(count), 32'd15);
    check("full_ovf", 32'(ovf), 32'd1);
    drain();
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // wrap: repeated write/drain across pointer wrap
    for (int k = 0; k < 20; k++) begin
      step(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
      idle_n(3);
      for (int j = 0; j < 3; j++) step(1'b0, '0, '0, 1'b1, 1'b0);
    end

    // read in the same cycle as the w1 write, with one word stored
    step(1'b1, 24'hA1B2C3, 24'hD4E5F6, 1'b0, 1'b0);
    idle_n(1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("simul_count", 32'(count), 32'd1);
    check("simul_dout", 32'(dout), 32'hA1B2);
    drain();

    // mid-sample flush, then a strobe right after is accepted
    step(1'b1, 24'h0F0F0F, 24'hF0F0F0, 1'b0, 1'b0);
    idle_n(1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_idle", 32'(wr_state), 32'(IDLE));
    step(1'b1, 24'h765432, 24'h89ABCD, 1'b0, 1'b0);
    idle_n(3);
    check("flush_count3", 32'(count), 32'd3);
    drain();

    // random traffic
    for (int k = 0; k < 500; k++) begin
      step(($urandom_range(0, 2) == 0), W'($urandom), W'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
